core_scheduler: RTL and testbench
=================================

CORE_SCHEDULER -- requirements
Module: core_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CORES, default 4, number of convolution cores scheduled.
REQ-002 The block SHALL have parameter JOB_DEPTH, default 4, job queue entries (power of two).
REQ-003 The block SHALL have parameter JOB_W, default 8, job identifier width.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 1024, watchdog limit in cycles.
REQ-005 The block SHALL have port clk, input, 1, single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port job_valid, input, 1, job offered.
REQ-008 The block SHALL have port job_id, input, JOB_W, identifier of the offered job.
REQ-009 The block SHALL have port job_ready, output, 1, queue can accept a job.
REQ-010 The block SHALL have port core_start, output, NUM_CORES, one-cycle start pulse per core.
REQ-011 The block SHALL have port core_clr, output, NUM_CORES, one-cycle core clear pulse per core.
REQ-012 The block SHALL have port core_job, output, NUM_CORES*JOB_W, job id held per core.
REQ-013 The block SHALL have port core_done, input, NUM_CORES, level done from each core (sticky until cleared).
REQ-014 The block SHALL have ports cpl_valid (output, 1), cpl_ready (input, 1), cpl_id (output, JOB_W), cpl_core (output, clog2(NUM_CORES)) and cpl_err (output, 1), which form the completion record.
REQ-015 The block SHALL have port idle, output, 1, high when the queue is empty and all cores are IDLE.

Function
REQ-016 A job SHALL be enqueued on a cycle with job_valid && job_ready; job_ready = queue not full, with no bypass.
REQ-017 Each core SHALL have states IDLE, RUN and CLEAR.
REQ-018 When the queue is non-empty and at least one core is IDLE, the block SHALL pop one job, select the first IDLE core at or after rr_ptr (wrapping modulo NUM_CORES), and register core_start[k]=1 and core_job[k]=job; core k SHALL go to RUN; rr_ptr SHALL advance to k+1 mod NUM_CORES.
REQ-019 At most one dispatch SHALL occur per cycle, and the earliest core_start SHALL be one cycle after enqueue.
REQ-020 A core in RUN with core_done high SHALL become a completion candidate; core_done SHALL be ignored outside RUN.
REQ-021 When no completion record is held, or the held record is accepted this cycle, the block SHALL load the lowest-index candidate into cpl_*; that core SHALL pulse core_clr for one cycle, go to CLEAR, and return to IDLE next cycle. Other candidates SHALL wait in RUN.
REQ-022 cpl_valid SHALL hold with cpl_* stable until cpl_ready; the transfer SHALL occur on cpl_valid && cpl_ready.
REQ-023 Enqueue, dispatch, completion load and completion accept SHALL all be allowed in the same cycle.
REQ-024 A core freed (CLEAR->IDLE) SHALL be dispatchable on the cycle it reads IDLE, not earlier.

Reset
REQ-025 While rst=0, the block SHALL empty the queue, set all cores to IDLE, set rr_ptr=0, and drive core_start=0, core_clr=0, core_job=0, cpl_valid=0, cpl_id=0, cpl_core=0, cpl_err=0, job_ready=0 and idle=1; job_ready SHALL go to 1 the first cycle after release.
REQ-026 A reset asserted mid-job SHALL discard queued jobs and any held completion record without producing a core_clr pulse.

Configuration
REQ-027 With SCHED_TIMEOUT_EN defined, each core SHALL have a counter that clears on entering RUN and increments in RUN; reaching TIMEOUT_CYC SHALL make the core a candidate with cpl_err=1 and the normal clear sequence.
REQ-028 Without SCHED_TIMEOUT_EN, the block SHALL have no counters and cpl_err SHALL be tied to 0.

Structure
REQ-029 Package sched_pkg SHALL hold the core state enum (IDLE/RUN/CLEAR) and the default width constants.
REQ-030 The job queue SHALL be sub-module sched_job_fifo (synchronous FIFO, full/empty, pointer wrap).

Verification
REQ-031 The bench SHALL enqueue jobs 0x11, 0x22, 0x33, 0x44, 0x55 with cores never done -> cores 0..3 started with 0x11..0x44, 0x55 queued, idle=0.
REQ-032 The bench SHALL fill the queue with 4 jobs while all cores are busy -> job_ready=0; a fifth job_valid SHALL not be accepted.
REQ-033 The bench SHALL raise core_done[2] and core_done[0] together with cpl_ready=1 -> core 0 completes first, core 2 the next cycle, each with one core_clr pulse.
REQ-034 The bench SHALL hold cpl_ready=0 for 5 cycles -> cpl_id/cpl_core stable, and the second done core stays in RUN.
REQ-035 With SCHED_TIMEOUT_EN and TIMEOUT_CYC=16, a core never done -> completion with cpl_err=1, core cleared, and the next queued job dispatched.
REQ-036 The bench SHALL drop rst to 0 during RUN with 2 jobs queued -> all outputs at reset values and idle=1; no completion after release.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and default sizing for the core scheduler.
package sched_pkg;

  // Per-core lifecycle: dispatched into Run, one cycle of Clear after completion.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StClear = 2'd2
  } core_state_e;

  localparam int unsigned DefNumCores   = 4;
  localparam int unsigned DefJobDepth   = 4;
  localparam int unsigned DefJobW       = 8;
  localparam int unsigned DefTimeoutCyc = 1024;

endpackage

// File: rtl/sched_job_fifo.sv
// Synchronous job FIFO; Depth must be a power of two >= 2.
// Pointers carry one extra wrap bit to tell full from empty.
module sched_job_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  // Pointer update; reset empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/core_scheduler.sv
// Core scheduler: queues jobs, dispatches them round-robin to idle cores and
// hands back one completion record at a time, clearing the finished core.
// Optional per-core watchdog enabled by defining SCHED_TIMEOUT_EN.
module core_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned  NUM_CORES   = DefNumCores,
  parameter int unsigned  JOB_DEPTH   = DefJobDepth,
  parameter int unsigned  JOB_W       = DefJobW,
  parameter int unsigned  TIMEOUT_CYC = DefTimeoutCyc,
  localparam int unsigned CoreW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  input  logic [JOB_W-1:0]         job_id,
  output logic                     job_ready,
  output logic [NUM_CORES-1:0]     core_start,
  output logic [NUM_CORES-1:0]     core_clr,
  output logic [NUM_CORES*JOB_W-1:0] core_job,
  input  logic [NUM_CORES-1:0]     core_done,
  output logic                     cpl_valid,
  input  logic                     cpl_ready,
  output logic [JOB_W-1:0]         cpl_id,
  output logic [CoreW-1:0]         cpl_core,
  output logic                     cpl_err,
  output logic                     idle
);

  if (TIMEOUT_CYC == 0 || JOB_DEPTH < 2 || (JOB_DEPTH & (JOB_DEPTH - 1)) != 0) begin : g_cfg_err
    $error("core_scheduler: JOB_DEPTH must be a power of two >= 2, TIMEOUT_CYC nonzero");
  end

  core_state_e                    state_q [NUM_CORES];
  core_state_e                    state_d [NUM_CORES];
  logic [CoreW-1:0]               rr_ptr_q;
  logic [NUM_CORES-1:0]           core_start_q, core_clr_q;
  logic [NUM_CORES-1:0][JOB_W-1:0] core_job_q;
  logic                           cpl_valid_q;
  logic [JOB_W-1:0]               cpl_id_q;
  logic [CoreW-1:0]               cpl_core_q;
  logic                           ready_q;

  logic                 fifo_full, fifo_empty, enq, dispatch, disp_hit, cpl_hit, cpl_load;
  logic [JOB_W-1:0]     fifo_head;
  logic [CoreW-1:0]     disp_idx, scan_idx, cpl_idx;
  logic [NUM_CORES-1:0] cand, tmo;

  // ready_q holds job_ready low through reset and for the release cycle.
  assign job_ready = ready_q & ~fifo_full;
  assign enq       = job_valid & job_ready;

  sched_job_fifo #(
    .Depth (JOB_DEPTH),
    .Width (JOB_W)
  ) u_job_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enq),
    .wdata (job_id),
    .pop   (dispatch),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // First idle core at or after rr_ptr, wrapping.
  always_comb begin
    disp_hit = 1'b0;
    disp_idx = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      scan_idx = CoreW'((32'(rr_ptr_q) + i) % NUM_CORES);
      if (!disp_hit && state_q[scan_idx] == StIdle) begin
        disp_hit = 1'b1;
        disp_idx = scan_idx;
      end
    end
    dispatch = disp_hit & ~fifo_empty;
  end

  // Lowest-index running core that is done (or timed out) gets the record slot.
  always_comb begin
    cand     = '0;
    cpl_hit  = 1'b0;
    cpl_idx  = '0;
    cpl_load = 1'b0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      cand[k] = (state_q[k] == StRun) && (core_done[k] || tmo[k]);
      if (cand[k] && !cpl_hit) begin
        cpl_hit = 1'b1;
        cpl_idx = CoreW'(k);
      end
    end
    cpl_load = cpl_hit && (!cpl_valid_q || cpl_ready);
  end

  // Per-core next state.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      state_d[k] = state_q[k];
      unique case (state_q[k])
        StIdle:  if (dispatch && disp_idx == CoreW'(k)) state_d[k] = StRun;
        StRun:   if (cpl_load && cpl_idx == CoreW'(k)) state_d[k] = StClear;
        StClear: state_d[k] = StIdle;
        default: state_d[k] = StIdle;
      endcase
    end
  end

  // Core state, dispatch and completion registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NUM_CORES; k++) state_q[k] <= StIdle;
      rr_ptr_q     <= '0;
      core_start_q <= '0;
      core_clr_q   <= '0;
      core_job_q   <= '0;
      cpl_valid_q  <= 1'b0;
      cpl_id_q     <= '0;
      cpl_core_q   <= '0;
      ready_q      <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_CORES; k++) state_q[k] <= state_d[k];
      ready_q      <= 1'b1;
      core_start_q <= '0;
      core_clr_q   <= '0;
      if (dispatch) begin
        core_start_q[disp_idx] <= 1'b1;
        core_job_q[disp_idx]   <= fifo_head;
        rr_ptr_q <= (disp_idx == CoreW'(NUM_CORES - 1)) ? '0 : disp_idx + CoreW'(1);
      end
      if (cpl_load) begin
        cpl_valid_q         <= 1'b1;
        cpl_id_q            <= core_job_q[cpl_idx];
        cpl_core_q          <= cpl_idx;
        core_clr_q[cpl_idx] <= 1'b1;
      end else if (cpl_valid_q && cpl_ready) begin
        cpl_valid_q <= 1'b0;
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] cnt_q [NUM_CORES];
  logic            cpl_err_q;

  // Watchdog per core: restart at dispatch, count while running, saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NUM_CORES; k++) cnt_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
        if (dispatch && disp_idx == CoreW'(k)) begin
          cnt_q[k] <= '0;
        end else if (state_q[k] == StRun && cnt_q[k] != CntW'(TIMEOUT_CYC)) begin
          cnt_q[k] <= cnt_q[k] + CntW'(1);
        end
      end
    end
  end

  // Timeout flags per core.
  always_comb begin
    tmo = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      tmo[k] = (state_q[k] == StRun) && (cnt_q[k] == CntW'(TIMEOUT_CYC));
    end
  end

  // A real done on the same cycle as expiry counts as a clean finish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cpl_err_q <= 1'b0;
    else if (cpl_load) cpl_err_q <= tmo[cpl_idx] & ~core_done[cpl_idx];
  end

  assign cpl_err = cpl_err_q;
`else
  assign tmo     = '0;
  assign cpl_err = 1'b0;
`endif

  // Idle when nothing is queued and every core is parked.
  always_comb begin
    idle = fifo_empty;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (state_q[k] != StIdle) idle = 1'b0;
    end
  end

  assign core_start = core_start_q;
  assign core_clr   = core_clr_q;
  assign core_job   = core_job_q;
  assign cpl_valid  = cpl_valid_q;
  assign cpl_id     = cpl_id_q;
  assign cpl_core   = cpl_core_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Scoreboard bench for core_scheduler: stimulus pushes expected dispatches and
// completion records; a negedge monitor pops and compares them.
module tb_core_scheduler;

  localparam int unsigned NC = 4;
  localparam int unsigned JW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            job_valid = 1'b0;
  logic [JW-1:0]   job_id = '0;
  logic            job_ready;
  logic [NC-1:0]   core_start, core_clr;
  logic [NC*JW-1:0] core_job;
  logic [NC-1:0]   core_done = '0;
  logic            cpl_valid;
  logic            cpl_ready = 1'b0;
  logic [JW-1:0]   cpl_id;
  logic [1:0]      cpl_core;
  logic            cpl_err;
  logic            idle;

  always #5 clk = ~clk;

  core_scheduler #(
    .NUM_CORES   (NC),
    .JOB_DEPTH   (4),
    .JOB_W       (JW),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .job_valid (job_valid),
    .job_id    (job_id),
    .job_ready (job_ready),
    .core_start(core_start),
    .core_clr  (core_clr),
    .core_job  (core_job),
    .core_done (core_done),
    .cpl_valid (cpl_valid),
    .cpl_ready (cpl_ready),
    .cpl_id    (cpl_id),
    .cpl_core  (cpl_core),
    .cpl_err   (cpl_err),
    .idle      (idle)
  );

  typedef struct packed {logic [1:0] core; logic [JW-1:0] job;} start_t;
  typedef struct packed {logic [JW-1:0] id; logic [1:0] core; logic err;} cpl_t;

  start_t exp_start[$];
  cpl_t   exp_cpl[$];
  start_t mon_s;
  cpl_t   mon_c;
  int     checks = 0;
  int     failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [JW-1:0] id);
    job_valid = 1'b1;
    job_id    = id;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (job_ready) begin
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL send_timeout: job 0x%0h not accepted, required within 20 cycles", id);
    job_valid = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_job_ready", job_ready, 0);
    check("rst_idle", idle, 1);
    check("rst_core_start", core_start, 0);
    check("rst_core_clr", core_clr, 0);
    check("rst_core_job", core_job, 0);
    check("rst_cpl_valid", cpl_valid, 0);
    check("rst_cpl_id", cpl_id, 0);
    check("rst_cpl_core", cpl_core, 0);
    check("rst_cpl_err", cpl_err, 0);
  endtask

  task automatic exp_go(input logic [1:0] core, input logic [JW-1:0] job);
    start_t s;
    s.core = core;
    s.job  = job;
    exp_start.push_back(s);
  endtask

  task automatic exp_done(input logic [JW-1:0] id, input logic [1:0] core, input logic err);
    cpl_t c;
    c.id   = id;
    c.core = core;
    c.err  = err;
    exp_cpl.push_back(c);
  endtask

  // Monitor: dispatches, completion transfers and clear pulses.
  always @(negedge clk) begin
    if (core_start != '0) begin
      check("start_onehot", $countones(core_start), 1);
      for (int k = 0; k < NC; k++) begin
        if (core_start[k]) begin
          if (exp_start.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL start_unexpected: core %0d got job 0x%0h, no start required", k,
                     core_job[k*JW +: JW]);
          end else begin
            mon_s = exp_start.pop_front();
            check("start_core", k, mon_s.core);
            check("start_job", core_job[k*JW +: JW], mon_s.job);
          end
        end
      end
    end
    if (cpl_valid && cpl_ready) begin
      if (exp_cpl.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cpl_unexpected: id 0x%0h core %0d, no completion required", cpl_id, cpl_core);
      end else begin
        mon_c = exp_cpl.pop_front();
        check("cpl_id", cpl_id, mon_c.id);
        check("cpl_core", cpl_core, mon_c.core);
        check("cpl_err", cpl_err, mon_c.err);
      end
    end
    if (core_clr != '0) begin
      check("clr_onehot", $onehot(core_clr), 1);
      check("clr_matches_cpl", {cpl_valid, core_clr[cpl_core]}, 2'b11);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    cyc(2);
    check_reset_vals();
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(1);
    check("ready_after_release", job_ready, 1);
    check("idle_after_release", idle, 1);

`ifdef SCHED_TIMEOUT_EN
    // Never-done cores expire; the queued fifth job goes to the first freed core.
    cpl_ready = 1'b1;
    exp_go(0, 8'hA1); exp_go(1, 8'hA2); exp_go(2, 8'hA3); exp_go(3, 8'hA4); exp_go(0, 8'hA5);
    exp_done(8'hA1, 0, 1); exp_done(8'hA2, 1, 1); exp_done(8'hA3, 2, 1);
    exp_done(8'hA4, 3, 1); exp_done(8'hA5, 0, 1);
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4); send(8'hA5);
    for (int t = 0; t < 150 && exp_cpl.size() != 0; t++) cyc(1);
    check("tmo_all_completed", exp_cpl.size(), 0);
    cyc(3);
    check("tmo_idle", idle, 1);
    // Refill all cores; rr_ptr sits at 1 after the A5 dispatch to core 0.
    exp_go(1, 8'hC1); exp_go(2, 8'hC2); exp_go(3, 8'hC3); exp_go(0, 8'hC4);
    send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
`else
    // Four cores take 0x11..0x44, 0x55 stays queued.
    exp_go(0, 8'h11); exp_go(1, 8'h22); exp_go(2, 8'h33); exp_go(3, 8'h44);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    cyc(2);
    @(negedge clk);
    check("busy_idle", idle, 0);
    check("busy_core_job", core_job, 32'h4433_2211);
    check("busy_ready", job_ready, 1);

    // Fill queue to 4; a further offer must be refused.
    @(posedge clk);
    #1;
    send(8'h66); send(8'h77); send(8'h88);
    @(negedge clk);
    check("full_ready", job_ready, 0);
    job_valid = 1'b1;
    job_id    = 8'h99;
    repeat (3) begin
      @(negedge clk);
      check("full_hold_ready", job_ready, 0);
    end
    @(posedge clk);
    #1 job_valid = 1'b0;

    // Cores 2 and 0 done together: core 0 first, then core 2.
    exp_done(8'h11, 0, 0); exp_done(8'h33, 2, 0);
    exp_go(0, 8'h55); exp_go(2, 8'h66);
    cpl_ready = 1'b1;
    core_done = 4'b0101;
    cyc(2);
    core_done = 4'b0000;
    cyc(4);
    @(negedge clk);
    check("redispatch_core_job", core_job, 32'h4466_2255);

    // Stall the record for 5 cycles; core 3 must wait behind core 1.
    @(posedge clk);
    #1;
    exp_done(8'h22, 1, 0); exp_done(8'h44, 3, 0);
    exp_go(1, 8'h77); exp_go(3, 8'h88);
    cpl_ready = 1'b0;
    core_done = 4'b1010;
    cyc(1);
    core_done = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", cpl_valid, 1);
      check("stall_id", cpl_id, 8'h22);
      check("stall_core", cpl_core, 1);
      check("stall_no_clr3", core_clr[3], 0);
      @(posedge clk);
      #1;
    end
    cpl_ready = 1'b1;
    cyc(1);
    core_done = 4'b0000;
    cyc(4);
    @(negedge clk);
    check("stall_core_job", core_job, 32'h8866_7755);
    check("stall_idle", idle, 0);
    @(posedge clk);
    #1;
`endif

    // Two jobs queued behind busy cores, then reset mid-job.
    send(8'hB1); send(8'hB2);
    cyc(2);
    @(negedge clk);
    check("pre_rst_ready", job_ready, 1);
    check("pre_rst_idle", idle, 0);
    #2 rst = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk);
    #3 rst = 1'b1;
    cyc(1);
    check("post_rst_ready", job_ready, 1);
    check("post_rst_idle", idle, 1);
    cpl_ready = 1'b1;
    core_done = 4'b1111;
    repeat (10) begin
      @(negedge clk);
      check("post_rst_no_cpl", cpl_valid, 0);
      check("post_rst_no_start", core_start, 0);
    end
    core_done = 4'b0000;

    cyc(2);
    check("sb_starts_drained", exp_start.size(), 0);
    check("sb_cpls_drained", exp_cpl.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
